mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port word memory (sync read, 1 clk latency, re/we strobes) between two
//  requesters: port 0 = CPU instruction fetch, port 1 = CPU load/store or DMA. It sits
//  between the requesters and the memory's re/we/addr/rdata/wdata pins. It issues at most
//  one command per cycle and routes read data back to the requester that owns it.
// PARAMETERS
//  AW          30  word address width
//  DW          32  data width
//  RD_LAT      1   memory read latency in clocks (1..4); sets the depth of the owner pipe
//  FIXED_PRIO  0   0 = round-robin; 1 = port 0 wins on conflict, subject to MAX_WAIT
//  MAX_WAIT    4   FIXED_PRIO=1 only: consecutive losses before port 1 is forced through
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst_n       in   1   asynchronous reset, active low
//  m0_req      in   1   port 0 command valid; hold with fields stable until m0_ack
//  m0_we       in   1   1 = write, 0 = read
//  m0_addr     in   AW  word address
//  m0_wdata    in   DW  write data
//  m0_ack      out  1   command accepted this cycle (combinational)
//  m0_rvalid   out  1   m0_rdata valid (reads only)
//  m0_rdata    out  DW  read data
//  m1_*        same set as m0_* for port 1
//  mem_re      out  1   memory read strobe
//  mem_we      out  1   memory write strobe
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, valid RD_LAT clocks after mem_re
// BEHAVIOUR
//  - Reset (rst_n=0, takes effect immediately): owner pipe cleared; last_grant=1 (so port 0
//    wins the first conflict); wait_cnt=0. Outputs: mN_rvalid=0, mN_ack=0, mem_re=0,
//    mem_we=0. mem_addr/mem_wdata/mN_rdata read as 0. Acks and strobes are gated by rst_n.
//  - Grant is combinational each cycle. One req -> that port is granted.
//    Both req with FIXED_PRIO=0 -> grant the port != last_grant.
//    Both req with FIXED_PRIO=1 -> grant port 0, unless wait_cnt==MAX_WAIT, then port 1.
//  - Granted port: mN_ack=1 in the same cycle. mem_addr/mem_wdata/mem_we are muxed from that
//    port; mem_re = ~mN_we. No grant: mem_re=mem_we=0 and mem_addr holds its last value.
//  - Posedge with a grant: last_grant <= granted port.
//    wait_cnt <= 0 when port 1 is granted or m1_req=0; wait_cnt <= wait_cnt+1
//    (saturating at MAX_WAIT) when port 1 requests and loses.
//  - Read return: an owner pipe RD_LAT deep shifts {valid, port} each clock. The issuing
//    read enters at stage 0. At the last stage: mN_rvalid=1 for that owner for exactly 1
//    clk, and mN_rdata=mem_rdata. The other port sees rvalid=0 and rdata=0.
//  - Throughput: back-to-back commands every cycle, reads and writes mixed, with no bubbles.
//    Returns stay in issue order. Write after read to the same address in consecutive
//    cycles: the read returns the old data (memory semantics, not hidden by the arbiter).
//  - Writes produce no rvalid.
//  - req dropped without ack: legal, no side effect.
//  - Reset with reads in flight: the pending returns are discarded and no rvalid is emitted.
//  - No other state machine: the arbiter is stateless apart from last_grant, wait_cnt and
//    the owner pipe.
// STRUCTURE
//  - Shared package mem_arb_pkg holds: PORT_IFETCH=1'b0, PORT_DATA=1'b1, the owner-pipe
//    entry struct {valid, port}, and the default AW/DW.
//  - One sub-module: arb_owner_pipe (RD_LAT-deep shift register of owner entries, async
//    reset). Grant logic and muxing stay in the top.
// TESTING
//  1 Reset then a single m0 read of addr 0x10 (mem[0x10]=0xDEADBEEF) -> m0_ack in cycle 0,
//    mem_re=1, m0_rvalid=1 with 0xDEADBEEF in cycle 1, m1_rvalid=0 throughout.
//  2 FIXED_PRIO=0, both ports hold read req for 6 cycles -> grants alternate 0,1,0,1,0,1;
//    rdata routed to the matching port one cycle after each grant.
//  3 FIXED_PRIO=1, MAX_WAIT=4, both request continuously -> port 0 granted 4x, then port 1
//    1x, pattern repeats; wait_cnt never exceeds 4.
//  4 m1 writes 0x12345678 to 0x20, then m0 reads 0x20 in the next cycle -> m0 gets
//    0x12345678; no m1_rvalid.
//  5 m0 read issued, rst_n pulsed low mid-cycle before the return -> no rvalid after
//    release; mem_re drops immediately while rst_n=0.
//  6 RD_LAT=3, 5 back-to-back alternating reads -> each rvalid arrives 3 clks after its
//    ack, in issue order, with the correct owner.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

   localparam int DEF_AW = 30;
   localparam int DEF_DW = 32;

   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_DATA   = 1'b1;

   typedef struct packed {
      logic valid;
      logic port;
   } owner_t;

endpackage

// File: rtl/arb_owner_pipe.sv
// rtl/arb_owner_pipe.sv - shift register tracking which port owns each in-flight read
module arb_owner_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  owner_t in_i,
   output owner_t out_o
);

   owner_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= in_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of a single-port sync-read memory
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int RD_LAT     = 1,
   parameter int FIXED_PRIO = 0,
   parameter int MAX_WAIT   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

   logic          last_grant_q, last_grant_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   logic          gnt_valid;
   logic          gnt_port;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   owner_t        issue;
   owner_t        retire;

   always_comb begin
      gnt_valid = rst_n & (m0_req | m1_req);
      if (m0_req && m1_req) begin
         if (FIXED_PRIO == 0) begin
            gnt_port = ~last_grant_q;
         end else begin
            gnt_port = (wait_cnt_q == WAIT_LIMIT) ? PORT_DATA : PORT_IFETCH;
         end
      end else begin
         gnt_port = m1_req ? PORT_DATA : PORT_IFETCH;
      end
      sel_we    = gnt_port ? m1_we    : m0_we;
      sel_addr  = gnt_port ? m1_addr  : m0_addr;
      sel_wdata = gnt_port ? m1_wdata : m0_wdata;
   end

   assign m0_ack    = gnt_valid & (gnt_port == PORT_IFETCH);
   assign m1_ack    = gnt_valid & (gnt_port == PORT_DATA);
   assign mem_re    = gnt_valid & ~sel_we;
   assign mem_we    = gnt_valid & sel_we;
   // Idle cycles replay the last command's address/data; both registers are 0 in reset.
   assign mem_addr  = gnt_valid ? sel_addr  : addr_q;
   assign mem_wdata = gnt_valid ? sel_wdata : wdata_q;

   always_comb begin
      addr_d       = mem_addr;
      wdata_d      = mem_wdata;
      last_grant_d = gnt_valid ? gnt_port : last_grant_q;
      wait_cnt_d   = wait_cnt_q;
      if (!m1_req || (gnt_valid && gnt_port == PORT_DATA)) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_LIMIT) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= PORT_DATA;
         wait_cnt_q   <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wait_cnt_q   <= wait_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign issue.valid = mem_re;
   assign issue.port  = gnt_port;

   arb_owner_pipe #(
      .DEPTH (RD_LAT)
   ) u_owner_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (issue),
      .out_o (retire)
   );

   assign m0_rvalid = rst_n & retire.valid & (retire.port == PORT_IFETCH);
   assign m1_rvalid = rst_n & retire.valid & (retire.port == PORT_DATA);
   assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter across three configurations
module tb_mem_port_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int N  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;

   logic [N-1:0]         m0_ack, m0_rvalid, m1_ack, m1_rvalid, mem_re, mem_we;
   logic [N-1:0][DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
   logic [N-1:0][AW-1:0] mem_addr;

   logic          bd_we   = 1'b0;
   logic [7:0]    bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   int tests_run = 0;
   int failed    = 0;

   always #5 clk = ~clk;

   // Instance 0: round-robin, RD_LAT=1. Instance 1: fixed priority. Instance 2: RD_LAT=3.
   for (genvar g = 0; g < N; g++) begin : g_inst
      localparam int LAT = (g == 2) ? 3 : 1;
      localparam int FP  = (g == 1) ? 1 : 0;
      logic [DW-1:0] mem [256];
      logic [DW-1:0] rp  [4];

      mem_port_arbiter #(
         .AW(AW), .DW(DW), .RD_LAT(LAT), .FIXED_PRIO(FP), .MAX_WAIT(4)
      ) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .m0_req    (m0_req),
         .m0_we     (m0_we),
         .m0_addr   (m0_addr),
         .m0_wdata  (m0_wdata),
         .m0_ack    (m0_ack[g]),
         .m0_rvalid (m0_rvalid[g]),
         .m0_rdata  (m0_rdata[g]),
         .m1_req    (m1_req),
         .m1_we     (m1_we),
         .m1_addr   (m1_addr),
         .m1_wdata  (m1_wdata),
         .m1_ack    (m1_ack[g]),
         .m1_rvalid (m1_rvalid[g]),
         .m1_rdata  (m1_rdata[g]),
         .mem_re    (mem_re[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
      );

      always @(posedge clk) begin
         if (bd_we) mem[bd_addr] <= bd_data;
         else if (mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
         rp[0] <= mem_re[g] ? mem[mem_addr[g][7:0]] : 32'h0;
         for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
      end

      assign mem_rdata[g] = rp[LAT-1];
   end

   function automatic logic [DW-1:0] pat(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5A5A5, a};
   endfunction

   task automatic idle();
      m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
   endtask

   task automatic preload();
      for (int a = 8'h10; a < 8'h48; a++) begin
         @(negedge clk);
         bd_we = 1'b1; bd_addr = 8'(a); bd_data = pat(8'(a));
      end
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_addr = 30'h3; m1_addr = 30'h4;
      #1;
      for (int g = 0; g < N; g++) begin
         tests_run++;
         if ({m0_ack[g], m1_ack[g], mem_re[g], mem_we[g], m0_rvalid[g], m1_rvalid[g]} !== 6'b0 ||
             mem_addr[g] !== '0 || mem_wdata[g] !== '0 || m0_rdata[g] !== '0 || m1_rdata[g] !== '0) begin
            failed++;
            $display("FAIL reset_outputs inst%0d got ack=%b%b re=%b we=%b rv=%b%b addr=%h want all 0",
                     g, m0_ack[g], m1_ack[g], mem_re[g], mem_we[g], m0_rvalid[g], m1_rvalid[g], mem_addr[g]);
         end
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h10;
      #1;
      tests_run++;
      if (m0_ack[0] !== 1'b1 || m1_ack[0] !== 1'b0 || mem_re[0] !== 1'b1 || mem_we[0] !== 1'b0 ||
          mem_addr[0] !== 30'h10 || m1_rvalid[0] !== 1'b0) begin
         failed++;
         $display("FAIL single_issue got ack=%b%b re=%b we=%b addr=%h want ack=10 re=1 we=0 addr=10",
                  m0_ack[0], m1_ack[0], mem_re[0], mem_we[0], mem_addr[0]);
      end
      @(negedge clk);
      idle();
      #1;
      tests_run++;
      if (m0_rvalid[0] !== 1'b1 || m0_rdata[0] !== 32'hDEADBEEF) begin
         failed++;
         $display("FAIL single_return got rv=%b data=%h want 1 deadbeef", m0_rvalid[0], m0_rdata[0]);
      end
      tests_run++;
      if (m1_rvalid[0] !== 1'b0 || m1_rdata[0] !== '0) begin
         failed++;
         $display("FAIL single_other_port got rv=%b data=%h want 0 0", m1_rvalid[0], m1_rdata[0]);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (m0_rvalid[0] !== 1'b0 || mem_re[0] !== 1'b0 || mem_addr[0] !== 30'h10) begin
         failed++;
         $display("FAIL single_idle got rv=%b re=%b addr=%h want 0 0 10", m0_rvalid[0], mem_re[0], mem_addr[0]);
      end
   endtask

   task automatic test_round_robin();
      logic p, q;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k < 6) begin
            m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
            m0_addr = 30'h10; m1_addr = 30'h11;
         end else begin
            idle();
         end
         #1;
         if (k < 6) begin
            p = k[0];
            tests_run++;
            if ({m1_ack[0], m0_ack[0]} !== (p ? 2'b10 : 2'b01) || mem_addr[0] !== (p ? 30'h11 : 30'h10)) begin
               failed++;
               $display("FAIL rr_grant cycle%0d got ack1/0=%b%b addr=%h want port %0d",
                        k, m1_ack[0], m0_ack[0], mem_addr[0], p);
            end
         end
         if (k > 0) begin
            q = ~k[0];
            tests_run++;
            if ({m1_rvalid[0], m0_rvalid[0]} !== (q ? 2'b10 : 2'b01) ||
                (q ? m1_rdata[0] : m0_rdata[0]) !== pat(q ? 8'h11 : 8'h10) ||
                (q ? m0_rdata[0] : m1_rdata[0]) !== '0) begin
               failed++;
               $display("FAIL rr_return cycle%0d got rv1/0=%b%b d0=%h d1=%h want port %0d",
                        k, m1_rvalid[0], m0_rvalid[0], m0_rdata[0], m1_rdata[0], q);
            end
         end
      end
   endtask

   task automatic test_fixed_prio();
      logic p;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
         m0_addr = 30'h12; m1_addr = 30'h13;
         #1;
         p = ((k % 5) == 4);
         tests_run++;
         if ({m1_ack[1], m0_ack[1]} !== (p ? 2'b10 : 2'b01)) begin
            failed++;
            $display("FAIL fp_grant cycle%0d got ack1/0=%b%b want port %0d", k, m1_ack[1], m0_ack[1], p);
         end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_write_then_read();
      @(negedge clk);
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h20; m1_wdata = 32'h12345678;
      #1;
      tests_run++;
      if (m1_ack[0] !== 1'b1 || m0_ack[0] !== 1'b0 || mem_we[0] !== 1'b1 || mem_re[0] !== 1'b0 ||
          mem_addr[0] !== 30'h20 || mem_wdata[0] !== 32'h12345678) begin
         failed++;
         $display("FAIL wr_issue got ack1=%b we=%b re=%b addr=%h wdata=%h want 1 1 0 20 12345678",
                  m1_ack[0], mem_we[0], mem_re[0], mem_addr[0], mem_wdata[0]);
      end
      @(negedge clk);
      m1_req = 1'b0; m1_we = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h20;
      #1;
      tests_run++;
      if (m0_ack[0] !== 1'b1 || mem_re[0] !== 1'b1 || m1_rvalid[0] !== 1'b0 || m0_rvalid[0] !== 1'b0) begin
         failed++;
         $display("FAIL wr_no_rvalid got ack0=%b re=%b rv1/0=%b%b want 1 1 00",
                  m0_ack[0], mem_re[0], m1_rvalid[0], m0_rvalid[0]);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (m0_rvalid[0] !== 1'b1 || m0_rdata[0] !== 32'h12345678 || m1_rvalid[0] !== 1'b0) begin
         failed++;
         $display("FAIL raw_data got rv=%b data=%h want 1 12345678", m0_rvalid[0], m0_rdata[0]);
      end
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h20; m1_wdata = 32'hAAAA5555;
      #1;
      tests_run++;
      if (m1_ack[0] !== 1'b1 || mem_we[0] !== 1'b1 || m0_rvalid[0] !== 1'b1 || m0_rdata[0] !== 32'h12345678) begin
         failed++;
         $display("FAIL war_old_data got ack1=%b we=%b rv=%b data=%h want 1 1 1 12345678",
                  m1_ack[0], mem_we[0], m0_rvalid[0], m0_rdata[0]);
      end
      @(negedge clk);
      m1_req = 1'b0; m1_we = 1'b0; m0_req = 1'b1; m0_addr = 30'h20;
      #1;
      tests_run++;
      if (m0_rvalid[0] !== 1'b0 || m1_rvalid[0] !== 1'b0) begin
         failed++;
         $display("FAIL war_no_rvalid got rv1/0=%b%b want 00", m1_rvalid[0], m0_rvalid[0]);
      end
      @(negedge clk);
      idle();
      #1;
      tests_run++;
      if (m0_rvalid[0] !== 1'b1 || m0_rdata[0] !== 32'hAAAA5555) begin
         failed++;
         $display("FAIL war_new_data got rv=%b data=%h want 1 aaaa5555", m0_rvalid[0], m0_rdata[0]);
      end
   endtask

   task automatic test_reset_in_flight();
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h10;
      #1;
      tests_run++;
      if (m0_ack[2] !== 1'b1 || mem_re[2] !== 1'b1) begin
         failed++;
         $display("FAIL rif_issue got ack=%b re=%b want 1 1", m0_ack[2], mem_re[2]);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int g = 0; g < N; g++) begin
         tests_run++;
         if (mem_re[g] !== 1'b0 || m0_ack[g] !== 1'b0 || m0_rvalid[g] !== 1'b0 || mem_addr[g] !== '0) begin
            failed++;
            $display("FAIL rif_during_reset inst%0d got re=%b ack=%b rv=%b addr=%h want 0 0 0 0",
                     g, mem_re[g], m0_ack[g], m0_rvalid[g], mem_addr[g]);
         end
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests_run++;
         if (m0_rvalid !== '0 || m1_rvalid !== '0) begin
            failed++;
            $display("FAIL rif_after_release cycle%0d got m0_rv=%b m1_rv=%b want 000 000", c, m0_rvalid, m1_rvalid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rd_lat3();
      logic p;
      logic [7:0] a;
      int i;
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (j < 5) begin
            m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
            m0_addr = 30'h30 + 30'(j); m1_addr = 30'h40 + 30'(j);
         end else begin
            idle();
         end
         #1;
         if (j < 5) begin
            p = j[0];
            tests_run++;
            if ({m1_ack[2], m0_ack[2]} !== (p ? 2'b10 : 2'b01)) begin
               failed++;
               $display("FAIL lat3_grant cycle%0d got ack1/0=%b%b want port %0d", j, m1_ack[2], m0_ack[2], p);
            end
         end
         tests_run++;
         if (j >= 3 && j < 8) begin
            i = j - 3;
            p = i[0];
            a = (p ? 8'h40 : 8'h30) + 8'(i);
            if ({m1_rvalid[2], m0_rvalid[2]} !== (p ? 2'b10 : 2'b01) ||
                (p ? m1_rdata[2] : m0_rdata[2]) !== pat(a) || (p ? m0_rdata[2] : m1_rdata[2]) !== '0) begin
               failed++;
               $display("FAIL lat3_return cycle%0d got rv1/0=%b%b d0=%h d1=%h want port %0d data %h",
                        j, m1_rvalid[2], m0_rvalid[2], m0_rdata[2], m1_rdata[2], p, pat(a));
            end
         end else if ({m1_rvalid[2], m0_rvalid[2]} !== 2'b00) begin
            failed++;
            $display("FAIL lat3_quiet cycle%0d got rv1/0=%b%b want 00", j, m1_rvalid[2], m0_rvalid[2]);
         end
      end
   endtask

   initial begin
      preload();
      test_reset();
      test_single_read();
      test_reset();
      test_round_robin();
      test_reset();
      test_fixed_prio();
      test_write_then_read();
      test_reset_in_flight();
      test_reset();
      test_rd_lat3();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
